// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between the
// display fetch (fixed slots) and two round-robin client ports.
module vram_arbiter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int FB_W    = 160,
  parameter int FB_H    = 120,
  parameter int AW      = 15
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [9:0]    i_hpos,
  input  logic [9:0]    i_vpos,
  output logic [2:0]    o_pixel,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_we,
  output logic [2:0]    o_ram_wdata,
  input  logic [2:0]    i_ram_rdata,
  input  logic          i_a_valid,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [2:0]    i_a_wdata,
  output logic          o_a_ready,
  output logic          o_a_rvalid,
  output logic [2:0]    o_a_rdata,
  input  logic          i_b_valid,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [2:0]    i_b_wdata,
  output logic          o_b_ready,
  output logic          o_b_rvalid,
  output logic [2:0]    o_b_rdata
);

  localparam logic [9:0] L_HWRAP = 10'(H_TOTAL - 3);
  localparam logic [9:0] L_VLAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_HLAST = 10'(4 * FB_W - 7);
  localparam logic [9:0] L_VACT  = 10'(4 * FB_H);
  localparam logic [AW-1:0] L_FBSZ = AW'(FB_W * FB_H);

  logic          w_wrap;
  logic          w_lslot;
  logic [9:0]    w_line;
  logic [7:0]    w_row;
  logic [7:0]    w_col;
  logic          w_disp;
  logic [AW-1:0] w_disp_addr;
  logic          w_cslot;
  logic          w_a_go;
  logic          w_b_go;
  logic          w_go;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [2:0]    w_wdata;
  logic          w_oob;

  logic          r_last_b;
  logic [1:0]    r_disp_p;
  logic          r_rd0_v, r_rd0_b, r_rd0_oob;
  logic          r_rd1_v, r_rd1_b, r_rd1_oob;

  // Display slot decode: column 0 is fetched at the end of the
  // previous line, columns 1..159 one group ahead on this line.
  always_comb begin
    w_wrap  = (i_hpos == L_HWRAP);
    w_lslot = (i_hpos[1:0] == 2'b01) && (i_hpos <= L_HLAST);
    w_line  = i_vpos;
    w_col   = i_hpos[9:2] + 8'd1;
    if (w_wrap) begin
      w_line = (i_vpos == L_VLAST) ? 10'd0 : i_vpos + 10'd1;
      w_col  = 8'd0;
    end
    w_row       = w_line[9:2];
    w_disp      = (w_wrap || w_lslot) && (w_line < L_VACT);
    w_disp_addr = AW'({w_row, 7'd0}) + AW'({w_row, 5'd0})
                + AW'(w_col);
  end

  // Client grant: idle or unfavoured port yields to the other.
  always_comb begin
    w_cslot   = !i_rst && !w_disp;
    o_a_ready = w_cslot && (!i_b_valid || r_last_b);
    o_b_ready = w_cslot && (!i_a_valid || !r_last_b);
    w_a_go    = i_a_valid && o_a_ready;
    w_b_go    = i_b_valid && o_b_ready;
    w_go      = w_a_go || w_b_go;
    w_we      = w_a_go ? i_a_we    : i_b_we;
    w_addr    = w_a_go ? i_a_addr  : i_b_addr;
    w_wdata   = w_a_go ? i_a_wdata : i_b_wdata;
    w_oob     = (w_addr >= L_FBSZ);
  end

  // RAM port: display fetch wins its slot, else the granted client.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ram_addr  <= '0;
      o_ram_we    <= 1'b0;
      o_ram_wdata <= 3'd0;
      r_last_b    <= 1'b1;
    end else begin
      o_ram_we <= 1'b0;
      if (w_disp) begin
        o_ram_addr <= w_disp_addr;
      end else if (w_go) begin
        o_ram_addr  <= w_addr;
        o_ram_we    <= w_we && !w_oob;
        o_ram_wdata <= w_wdata;
      end
      if (w_a_go)
        r_last_b <= 1'b0;
      else if (w_b_go)
        r_last_b <= 1'b1;
    end
  end

  // Pixel pipe: capture RAM data two cycles after the slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_disp_p <= 2'b00;
      o_pixel  <= 3'd0;
    end else begin
      r_disp_p <= {r_disp_p[0], w_disp};
      if (r_disp_p[1])
        o_pixel <= i_ram_rdata;
    end
  end

  // Read pipe: tag reads by port, return in accept order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd0_v    <= 1'b0;
      r_rd0_b    <= 1'b0;
      r_rd0_oob  <= 1'b0;
      r_rd1_v    <= 1'b0;
      r_rd1_b    <= 1'b0;
      r_rd1_oob  <= 1'b0;
      o_a_rvalid <= 1'b0;
      o_a_rdata  <= 3'd0;
      o_b_rvalid <= 1'b0;
      o_b_rdata  <= 3'd0;
    end else begin
      r_rd0_v    <= w_go && !w_we;
      r_rd0_b    <= w_b_go;
      r_rd0_oob  <= w_oob;
      r_rd1_v    <= r_rd0_v;
      r_rd1_b    <= r_rd0_b;
      r_rd1_oob  <= r_rd0_oob;
      o_a_rvalid <= r_rd1_v && !r_rd1_b;
      o_b_rvalid <= r_rd1_v && r_rd1_b;
      if (r_rd1_v && !r_rd1_b)
        o_a_rdata <= r_rd1_oob ? 3'd0 : i_ram_rdata;
      if (r_rd1_v && r_rd1_b)
        o_b_rdata <= r_rd1_oob ? 3'd0 : i_ram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench with a behavioural RAM and
// bench-driven VGA position counters.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hpos, vpos;
  logic [2:0]  pixel;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata = 3'd0;
  logic        a_valid, a_we, a_ready, a_rvalid;
  logic [14:0] a_addr;
  logic [2:0]  a_wdata, a_rdata;
  logic        b_valid, b_we, b_ready, b_rvalid;
  logic [14:0] b_addr;
  logic [2:0]  b_wdata, b_rdata;

  int total = 0;
  int bad   = 0;

  logic [2:0] mem [0:19199];
  logic       loaded = 1'b0;

  vram_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_hpos(hpos), .i_vpos(vpos),
    .o_pixel(pixel),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .i_a_valid(a_valid), .i_a_we(a_we),
    .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_ready(a_ready), .o_a_rvalid(a_rvalid),
    .o_a_rdata(a_rdata),
    .i_b_valid(b_valid), .i_b_we(b_we),
    .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ready(b_ready), .o_b_rvalid(b_rvalid),
    .o_b_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM preloaded with (row+col)&7 at the first edge.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int r = 0; r < 120; r++)
        for (int c = 0; c < 160; c++)
          mem[r*160+c] <= 3'((r + c) & 7);
      loaded <= 1'b1;
    end else if (ram_we && ram_addr < 15'd19200) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= (ram_addr < 15'd19200) ? mem[ram_addr] : 3'd0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    if (hpos == 10'd799) begin
      hpos = 10'd0;
      vpos = (vpos == 10'd524) ? 10'd0 : vpos + 10'd1;
    end else begin
      hpos = hpos + 10'd1;
    end
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic exp_rdy;

  initial begin
    rst = 1'b1;
    hpos = 10'd100; vpos = 10'd500;
    a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    repeat (3) tick();

    // reset state
    a_valid = 1; b_valid = 1; #1;
    chk("rst_pixel", 32'(pixel), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_arv", 32'(a_rvalid), 0);
    chk("rst_brv", 32'(b_rvalid), 0);
    chk("rst_ardy", 32'(a_ready), 0);
    chk("rst_brdy", 32'(b_ready), 0);

    // round robin writes then read back
    a_we = 1; a_addr = 15'd100; a_wdata = 3'd5;
    b_we = 1; b_addr = 15'd200; b_wdata = 3'd3;
    rst = 0; #1;
    chk("rr0_ardy", 32'(a_ready), 1);
    chk("rr0_brdy", 32'(b_ready), 0);
    tick(); a_addr = 15'd101; a_wdata = 3'd6; #1;
    chk("rr1_brdy", 32'(b_ready), 1);
    chk("rr1_ardy", 32'(a_ready), 0);
    chk("rr1_we", 32'(ram_we), 1);
    chk("rr1_addr", 32'(ram_addr), 100);
    chk("rr1_wd", 32'(ram_wdata), 5);
    tick(); b_addr = 15'd201; b_wdata = 3'd2; #1;
    chk("rr2_ardy", 32'(a_ready), 1);
    chk("rr2_brdy", 32'(b_ready), 0);
    chk("rr2_addr", 32'(ram_addr), 200);
    chk("rr2_wd", 32'(ram_wdata), 3);
    tick(); a_valid = 0; #1;
    chk("rr3_brdy", 32'(b_ready), 1);
    chk("rr3_addr", 32'(ram_addr), 101);
    chk("rr3_wd", 32'(ram_wdata), 6);
    tick(); b_valid = 0;
    a_valid = 1; a_we = 0; a_addr = 15'd100; #1;
    chk("rr4_addr", 32'(ram_addr), 201);
    chk("rr4_wd", 32'(ram_wdata), 2);
    chk("rr4_we", 32'(ram_we), 1);
    chk("rd0_ardy", 32'(a_ready), 1);
    tick(); a_valid = 0; #1;
    chk("rd1_we", 32'(ram_we), 0);
    chk("rd1_addr", 32'(ram_addr), 100);
    chk("rd1_rv", 32'(a_rvalid), 0);
    tick();
    chk("rd2_rv", 32'(a_rvalid), 0);
    tick();
    chk("rd3_rv", 32'(a_rvalid), 1);
    chk("rd3_data", 32'(a_rdata), 5);
    tick();
    chk("rd4_rv", 32'(a_rvalid), 0);

    // bounds on client B
    tick();
    b_valid = 1; b_we = 1; b_addr = 15'd19200; b_wdata = 3'd7; #1;
    chk("oob0_brdy", 32'(b_ready), 1);
    tick(); b_we = 0; b_addr = 15'd19199; #1;
    chk("oob1_we", 32'(ram_we), 0);
    tick(); b_addr = 15'd19200; #1;
    chk("oob2_we", 32'(ram_we), 0);
    tick(); b_valid = 0; #1;
    chk("oob3_we", 32'(ram_we), 0);
    chk("oob3_rv", 32'(b_rvalid), 0);
    tick();
    chk("oob4_rv", 32'(b_rvalid), 1);
    chk("oob4_data", 32'(b_rdata), 6);
    tick();
    chk("oob5_rv", 32'(b_rvalid), 1);
    chk("oob5_data", 32'(b_rdata), 0);
    tick();
    chk("oob6_rv", 32'(b_rvalid), 0);

    // wrap fetch, slot guard and display of row 0
    tick();
    hpos = 10'd795; vpos = 10'd524;
    a_valid = 1; a_we = 0; a_addr = 15'd5; #1;
    for (int k = 0; k < 805; k++) begin
      exp_rdy = !(hpos == 10'd797 ||
                  (vpos == 10'd0 && hpos[1:0] == 2'b01 &&
                   hpos <= 10'd633));
      chk("guard_ardy", 32'(a_ready), 32'(exp_rdy));
      if (vpos == 10'd524 && hpos == 10'd798)
        chk("wrap_addr", 32'(ram_addr), 0);
      if (vpos == 10'd0) begin
        if (hpos == 10'd0)   chk("px_r0c0", 32'(pixel), 0);
        if (hpos == 10'd4)   chk("px_r0c1", 32'(pixel), 1);
        if (hpos == 10'd8)   chk("px_r0c2", 32'(pixel), 2);
        if (hpos == 10'd636) chk("px_r0c159", 32'(pixel), 7);
        if (hpos == 10'd639) chk("px_r0c159e", 32'(pixel), 7);
      end
      tick();
    end

    // display of row 119
    a_valid = 0;
    hpos = 10'd795; vpos = 10'd475; #1;
    for (int k = 0; k < 646; k++) begin
      if (vpos == 10'd475 && hpos == 10'd798)
        chk("r119_addr", 32'(ram_addr), 19040);
      if (vpos == 10'd476 && hpos == 10'd0)
        chk("px_r119c0", 32'(pixel), 7);
      if (vpos == 10'd476 && hpos == 10'd636)
        chk("px_r119c159", 32'(pixel), 6);
      tick();
    end

    // mid-operation reset with a read in flight
    hpos = 10'd100; vpos = 10'd500;
    a_valid = 1; a_we = 0; a_addr = 15'd7; #1;
    tick(); a_valid = 0;
    tick();
    rst = 1; #1;
    chk("mrst_pixel", 32'(pixel), 0);
    chk("mrst_addr", 32'(ram_addr), 0);
    chk("mrst_we", 32'(ram_we), 0);
    chk("mrst_ardy", 32'(a_ready), 0);
    tick(); tick();
    rst = 0; #1;
    for (int k = 0; k < 4; k++) begin
      chk("mrst_arv", 32'(a_rvalid), 0);
      chk("mrst_brv", 32'(b_rvalid), 0);
      tick();
    end
    a_valid = 1; b_valid = 1; #1;
    chk("mrst_ardy1", 32'(a_ready), 1);
    chk("mrst_brdy1", 32'(b_ready), 0);
    tick();
    a_valid = 0; b_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
